// File: rtl/sd_cmd_serial_host_p_if.sv
// Command-master side bundle of the SD CMD-line host: request handshake, response
// settings, abort and the completion/status/response word.
interface sd_cmd_serial_host_p_if;
    logic         abort_i;
    logic         cmd_valid_i;
    logic         cmd_ready_o;
    logic [37:0]  cmd_i;
    logic [1:0]   rsp_type_i;
    logic         crc_chk_i;
    logic         idx_chk_i;
    logic         done_o;
    logic [3:0]   status_o;
    logic [133:0] rsp_o;

    modport master (
        output abort_i, cmd_valid_i, cmd_i, rsp_type_i, crc_chk_i, idx_chk_i,
        input  cmd_ready_o, done_o, status_o, rsp_o
    );

    modport slave (
        input  abort_i, cmd_valid_i, cmd_i, rsp_type_i, crc_chk_i, idx_chk_i,
        output cmd_ready_o, done_o, status_o, rsp_o
    );
endinterface

// File: rtl/sd_cmd_serial_host_p.sv
// SD CMD-line serialiser/deserialiser: sends 48-bit commands, captures R1/R2 responses.
// Optional macro SD_CMD_TIMEOUT_EN enables the response-start timeout in WAIT.
module sd_cmd_serial_host_p #(
    parameter int unsigned INIT_DELAY  = 64,
    parameter int unsigned NCR_MIN     = 2,
    parameter int unsigned RSP_TIMEOUT = 64,
    parameter int unsigned NRC_CYCLES  = 8
) (
    input  logic                     SD_CLK_IN,
    input  logic                     RST_IN,
    sd_cmd_serial_host_p_if.slave    bus,
    input  logic                     cmd_dat_i,
    output logic                     cmd_out_o,
    output logic                     cmd_oe_o
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_TX,
        S_WAIT,
        S_RX,
        S_NRC
    } state_t;

    localparam logic [15:0] INIT_LAST = 16'(INIT_DELAY - 1);
    localparam logic [15:0] NCR_OPEN  = 16'(NCR_MIN);
    localparam logic [15:0] WAIT_LAST = 16'(NCR_MIN + RSP_TIMEOUT - 1);
    localparam logic [15:0] NRC_LAST  = 16'(NRC_CYCLES - 1);

    state_t        state, state_nx;
    logic [15:0]   cnt;
    logic [39:0]   tx_sr;
    logic [6:0]    crc_q;
    logic [133:0]  rx_sr;
    logic [134:0]  rx_full;
    logic [5:0]    idx_q;
    logic          has_rsp_q;
    logic          long_q;
    logic          crc_chk_q;
    logic          idx_chk_q;

    logic          accept;
    logic          start_seen;
    logic          timeout_hit;
    logic          rx_last;
    logic          rx_done;
    logic          crc_in_range;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    assign accept     = (state == S_IDLE) && bus.cmd_valid_i && !bus.abort_i;
    assign start_seen = (state == S_WAIT) && (cnt >= NCR_OPEN) && !cmd_dat_i;
    assign rx_last    = (cnt == (long_q ? 16'd134 : 16'd46));
    assign rx_done    = (state == S_RX) && rx_last && !bus.abort_i;
    assign rx_full    = {rx_sr, cmd_dat_i};

    // Long responses skip start, tx and the 6 reserved bits before the CRC window.
    assign crc_in_range = long_q ? ((cnt >= 16'd7) && (cnt <= 16'd126)) : (cnt <= 16'd38);

`ifdef SD_CMD_TIMEOUT_EN
    assign timeout_hit = (state == S_WAIT) && (cnt == WAIT_LAST) && cmd_dat_i;
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge SD_CLK_IN) begin
        if (RST_IN) state <= S_INIT;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_INIT: if (cnt == INIT_LAST) state_nx = S_IDLE;
            S_IDLE: if (accept) state_nx = S_TX;
            S_TX: begin
                if (bus.abort_i)          state_nx = S_IDLE;
                else if (cnt == 16'd47)   state_nx = has_rsp_q ? S_WAIT : S_NRC;
            end
            S_WAIT: begin
                if (bus.abort_i)          state_nx = S_IDLE;
                else if (start_seen)      state_nx = S_RX;
                else if (timeout_hit)     state_nx = S_NRC;
            end
            S_RX: begin
                if (bus.abort_i)          state_nx = S_IDLE;
                else if (rx_last)         state_nx = S_NRC;
            end
            S_NRC: begin
                if (bus.abort_i)          state_nx = S_IDLE;
                else if (cnt == NRC_LAST) state_nx = S_IDLE;
            end
            default: state_nx = S_INIT;
        endcase
    end

    // Output logic
    always_comb begin
        cmd_out_o       = 1'b1;
        cmd_oe_o        = 1'b0;
        bus.cmd_ready_o = 1'b0;
        bus.done_o      = 1'b0;
        case (state)
            S_INIT: cmd_oe_o = 1'b1;
            S_IDLE: bus.cmd_ready_o = !bus.abort_i;
            S_TX: begin
                cmd_oe_o = 1'b1;
                if (cnt < 16'd40)      cmd_out_o = tx_sr[39];
                else if (cnt < 16'd47) cmd_out_o = crc_q[6];
                else                   cmd_out_o = 1'b1;
            end
            S_NRC: bus.done_o = (cnt == NRC_LAST) && !bus.abort_i;
            default: ;
        endcase
    end

    // Per-state counter; saturates in WAIT so an unbounded wait keeps the start window open.
    always_ff @(posedge SD_CLK_IN) begin
        if (RST_IN)
            cnt <= '0;
        else if (state_nx != state)
            cnt <= '0;
        else if (!((state == S_WAIT) && (cnt == WAIT_LAST)))
            cnt <= cnt + 16'd1;
    end

    always_ff @(posedge SD_CLK_IN) begin
        if (RST_IN) begin
            tx_sr     <= '0;
            crc_q     <= '0;
            rx_sr     <= '0;
            idx_q     <= '0;
            has_rsp_q <= 1'b0;
            long_q    <= 1'b0;
            crc_chk_q <= 1'b0;
            idx_chk_q <= 1'b0;
        end else begin
            if (accept) begin
                tx_sr     <= {2'b01, bus.cmd_i};
                crc_q     <= '0;
                idx_q     <= bus.cmd_i[37:32];
                has_rsp_q <= (bus.rsp_type_i != 2'b00);
                long_q    <= (bus.rsp_type_i == 2'b10);
                crc_chk_q <= bus.crc_chk_i;
                idx_chk_q <= bus.idx_chk_i;
            end else if (state == S_TX) begin
                tx_sr <= {tx_sr[38:0], 1'b0};
                // CRC accumulates over the first 40 bits, then shifts out behind them.
                if (cnt < 16'd40)      crc_q <= crc7_step(crc_q, tx_sr[39]);
                else if (cnt < 16'd47) crc_q <= {crc_q[5:0], 1'b0};
            end else if (start_seen) begin
                crc_q <= '0;
                rx_sr <= '0;
            end else if (state == S_RX) begin
                rx_sr <= {rx_sr[132:0], cmd_dat_i};
                if (crc_in_range) crc_q <= crc7_step(crc_q, cmd_dat_i);
            end
        end
    end

    always_ff @(posedge SD_CLK_IN) begin
        if (RST_IN) begin
            bus.status_o <= '0;
            bus.rsp_o    <= '0;
        end else if (accept) begin
            bus.status_o <= '0;
        end else if (rx_done) begin
            bus.status_o <= {!cmd_dat_i,
                             idx_chk_q && !long_q && (rx_full[45:40] != idx_q),
                             crc_chk_q && (crc_q != rx_full[7:1]),
                             1'b0};
            bus.rsp_o    <= long_q ? rx_full[134:1] : {88'b0, rx_full[46:1]};
        end else if (timeout_hit && !bus.abort_i) begin
            bus.status_o[0] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sd_cmd_serial_host_p.sv
// Directed bench for sd_cmd_serial_host_p: init hold, command framing, R1/R2 capture,
// error flags, timeout/indefinite wait, abort and mid-transfer reset.
module tb_sd_cmd_serial_host_p;

    logic clk = 1'b0;
    logic rst;
    logic cmd_dat, cmd_out, cmd_oe;
    int   checks = 0;
    int   errors = 0;
    int   cyc;
    int   at;
    logic [47:0]  txbits;
    logic         oe_ok;
    logic [135:0] fr;
    logic [133:0] long_rsp;
    logic [119:0] cid;

    always #5 clk = ~clk;

    sd_cmd_serial_host_p_if bus();

    sd_cmd_serial_host_p #(
        .INIT_DELAY (64),
        .NCR_MIN    (2),
        .RSP_TIMEOUT(64),
        .NRC_CYCLES (8)
    ) dut (
        .SD_CLK_IN(clk),
        .RST_IN   (rst),
        .bus      (bus.slave),
        .cmd_dat_i(cmd_dat),
        .cmd_out_o(cmd_out),
        .cmd_oe_o (cmd_oe)
    );

    task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference CRC7 over the n low bits of v, MSB first.
    function automatic logic [6:0] crc7(input logic [135:0] v, input int n);
        logic [6:0] c;
        logic fb;
        c = '0;
        for (int i = n - 1; i >= 0; i--) begin
            fb = v[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    function automatic logic [135:0] short_frame(input logic [5:0] idx, input logic [31:0] arg,
                                                 input logic [31:0] crc_arg, input logic endb);
        return {88'b0, 2'b00, idx, arg, crc7({96'b0, 2'b00, idx, crc_arg}, 40), endb};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input string tag);
        logic ok;
        rst = 1'b1;
        cmd_dat = 1'b1;
        bus.abort_i = 1'b0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_i = '0;
        bus.rsp_type_i = 2'b00;
        bus.crc_chk_i = 1'b0;
        bus.idx_chk_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_rst_pad"}, {cmd_oe, cmd_out}, 2'b11);
        check({tag, "_rst_hs"}, {bus.cmd_ready_o, bus.done_o}, 2'b00);
        check({tag, "_rst_status"}, bus.status_o, 4'h0);
        check({tag, "_rst_rsp"}, bus.rsp_o, '0);
        rst = 1'b0;
        ok = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            #1;
            if (k < 64 && !(cmd_oe === 1'b1 && cmd_out === 1'b1 && bus.cmd_ready_o === 1'b0))
                ok = 1'b0;
        end
        check({tag, "_init_hold"}, ok, 1'b1);
        check({tag, "_ready_at_64"}, bus.cmd_ready_o, 1'b1);
    endtask

    task automatic send(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                        input logic cc, input logic ic);
        @(negedge clk);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_i = {idx, arg};
        bus.rsp_type_i = rt;
        bus.crc_chk_i = cc;
        bus.idx_chk_i = ic;
        @(posedge clk);
        #1;
        bus.cmd_valid_i = 1'b0;
        cyc = 0;
        oe_ok = 1'b1;
        for (int i = 0; i < 48; i++) begin
            tick();
            txbits = {txbits[46:0], cmd_out};
            if (cmd_oe !== 1'b1) oe_ok = 1'b0;
        end
    endtask

    task automatic drive_rsp(input logic [135:0] f, input int len);
        repeat (4) tick();
        for (int i = len - 1; i >= 0; i--) begin
            cmd_dat = f[i];
            tick();
        end
        cmd_dat = 1'b1;
    endtask

    task automatic wait_done(input int budget, output int when);
        when = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.done_o === 1'b1) begin
                when = cyc;
                break;
            end
        end
    endtask

    initial begin
        do_reset("por");

        // CMD0, no response
        send(6'd0, 32'h0, 2'b00, 1'b0, 1'b0);
        check("cmd0_bits", txbits, 48'h40_0000_0000_95);
        check("cmd0_oe", oe_ok, 1'b1);
        wait_done(100, at);
        check("cmd0_done_cycle", at, 56);
        check("cmd0_status", bus.status_o, 4'h0);
        tick();
        check("cmd0_done_pulse", {bus.done_o, bus.cmd_ready_o}, 2'b01);

        // CMD17, good R1
        send(6'd17, 32'h0, 2'b01, 1'b1, 1'b1);
        check("cmd17_bits", txbits, 48'h51_0000_0000_55);
        fr = short_frame(6'd17, 32'h900, 32'h900, 1'b1);
        drive_rsp(fr, 48);
        wait_done(100, at);
        check("r1_done_cycle", at, 107);
        check("r1_status", bus.status_o, 4'h0);
        check("r1_rsp", bus.rsp_o, {88'b0, fr[46:1]});

        // Flipped argument bit, CRC check on
        send(6'd17, 32'h0, 2'b01, 1'b1, 1'b1);
        fr = short_frame(6'd17, 32'h901, 32'h900, 1'b1);
        drive_rsp(fr, 48);
        wait_done(100, at);
        check("crcerr_status", bus.status_o, 4'b0010);
        check("crcerr_rsp", bus.rsp_o, {88'b0, fr[46:1]});

        // Same corruption, CRC check off, type 11 behaves as short
        send(6'd17, 32'h0, 2'b11, 1'b0, 1'b1);
        drive_rsp(fr, 48);
        wait_done(100, at);
        check("crcoff_done_cycle", at, 107);
        check("crcoff_status", bus.status_o, 4'b0000);

        // Index mismatch
        send(6'd17, 32'h0, 2'b01, 1'b1, 1'b1);
        drive_rsp(short_frame(6'd18, 32'h900, 32'h900, 1'b1), 48);
        wait_done(100, at);
        check("idxerr_status", bus.status_o, 4'b0100);

        // Bad end bit
        send(6'd17, 32'h0, 2'b01, 1'b1, 1'b1);
        drive_rsp(short_frame(6'd17, 32'h900, 32'h900, 1'b0), 48);
        wait_done(100, at);
        check("enderr_status", bus.status_o, 4'b1000);

        // CMD2, R2 with CID
        cid = 120'h03_5344_5344_3032_8012_3456_7800_A1C5;
        fr = {2'b00, 6'h3F, cid, crc7({16'b0, cid}, 120), 1'b1};
        long_rsp = fr[134:1];
        send(6'd2, 32'h0, 2'b10, 1'b1, 1'b1);
        check("cmd2_bits", txbits, 48'h42_0000_0000_4D);
        drive_rsp(fr, 136);
        wait_done(200, at);
        check("r2_done_cycle", at, 195);
        check("r2_status", bus.status_o, 4'h0);
        check("r2_rsp", bus.rsp_o, long_rsp);

        // No start bit
        send(6'd17, 32'h0, 2'b01, 1'b1, 1'b1);
`ifdef SD_CMD_TIMEOUT_EN
        wait_done(300, at);
        check("timeout_done_cycle", at, 122);
        check("timeout_status", bus.status_o, 4'b0001);
        check("timeout_rsp_kept", bus.rsp_o, long_rsp);
`else
        wait_done(200, at);
        check("nowait_no_done", at, -1);
        check("nowait_busy", {bus.cmd_ready_o, cmd_oe}, 2'b00);
        bus.abort_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        #1;
        check("nowait_abort_idle", bus.cmd_ready_o, 1'b1);
        check("nowait_status", bus.status_o, 4'h0);
`endif

        // Abort mid-RX
        send(6'd17, 32'h0, 2'b01, 1'b1, 1'b1);
        fr = short_frame(6'd17, 32'h900, 32'h900, 1'b1);
        repeat (4) tick();
        for (int i = 47; i >= 37; i--) begin
            cmd_dat = fr[i];
            tick();
        end
        cmd_dat = 1'b1;
        bus.abort_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        #1;
        check("rxabort_idle_next", {bus.cmd_ready_o, cmd_oe}, 2'b10);
        wait_done(100, at);
        check("rxabort_no_done", at, -1);
        check("rxabort_status", bus.status_o, 4'h0);
        check("rxabort_rsp_kept", bus.rsp_o, long_rsp);

        // Abort together with valid in IDLE
        @(negedge clk);
        bus.abort_i = 1'b1;
        bus.cmd_valid_i = 1'b1;
        #1;
        check("abortvalid_ready", bus.cmd_ready_o, 1'b0);
        tick();
        bus.abort_i = 1'b0;
        bus.cmd_valid_i = 1'b0;
        #1;
        check("abortvalid_no_accept", {bus.cmd_ready_o, cmd_oe}, 2'b10);

        // Reset in the middle of a command
        @(negedge clk);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_i = '0;
        bus.rsp_type_i = 2'b00;
        @(posedge clk);
        #1;
        bus.cmd_valid_i = 1'b0;
        repeat (10) @(negedge clk);
        do_reset("midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
